// File: rtl/alu_seq_top.sv
// Switch/button ALU: synchronised, debounced button pulses drive a load-sequencing FSM
// whose execute step registers the ALU result, status flags and a valid strobe.
module alu_seq_top #(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_DATA-1:0] i_SWs,
    input  logic [2:0]         i_buttons,
    output logic [NB_DATA-1:0] o_led,
    output logic [3:0]         o_flags,
    output logic               o_valid,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        GOT_B = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    logic [2:0] sync1, sync2, deb, deb_prev, pulse;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb_prev <= '0;
            pulse    <= '0;
        end else begin
            sync1    <= i_buttons;
            sync2    <= sync1;
            deb_prev <= deb;
            pulse    <= deb & ~deb_prev;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb = sync2;
        end else begin : g_debounce
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            for (genvar i = 0; i < 3; i++) begin : g_btn
                logic [CW-1:0] cnt;
                logic          lvl;
                // Counter saturates at LAST; the level rises on the sample that finds it there.
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        cnt <= '0;
                        lvl <= 1'b0;
                    end else if (!sync2[i]) begin
                        cnt <= '0;
                        lvl <= 1'b0;
                    end else if (cnt == LAST) begin
                        lvl <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                assign deb[i] = lvl;
            end
        end
    endgenerate

    logic act_a, act_b, act_op;
    assign act_a  = pulse[2];
    assign act_b  = pulse[1] & ~pulse[2];
    assign act_op = pulse[0] & ~|pulse[2:1];

    state_t state, state_next;
    logic   load_a, load_b, exec, clr_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        exec       = 1'b0;
        clr_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (act_a) begin
                    load_a     = 1'b1;
                    state_next = GOT_A;
                end
            end
            GOT_A: begin
                if (act_a) begin
                    load_a = 1'b1;
                end else if (act_b) begin
                    load_b     = 1'b1;
                    state_next = GOT_B;
                end
            end
            GOT_B: begin
                if (act_a) begin
                    load_a = 1'b1;
                end else if (act_b) begin
                    load_b = 1'b1;
                end else if (act_op) begin
                    exec       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (act_a) begin
                    load_a     = 1'b1;
                    clr_valid  = 1'b1;
                    state_next = GOT_A;
                end else if (act_b) begin
                    load_b     = 1'b1;
                    clr_valid  = 1'b1;
                    state_next = GOT_B;
                end else if (act_op) begin
                    exec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic [NB_DATA-1:0] a_q, b_q, res;
    logic [NB_DATA:0]   sum, diff;
    logic [NB_OP-1:0]   op;
    logic               carry, ovf, invalid, zero, shift_big;
    logic [3:0]         flags;

    // The op code is consumed on the same edge it is loaded, so it is read straight from the switches.
    assign op        = i_SWs[NB_OP-1:0];
    assign sum       = {1'b0, a_q} + {1'b0, b_q};
    assign diff      = {1'b0, a_q} - {1'b0, b_q};
    assign shift_big = (b_q >= NB_DATA'(NB_DATA));

    always_comb begin
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        invalid = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[NB_DATA-1:0];
                carry = sum[NB_DATA];
                ovf   = (a_q[NB_DATA-1] == b_q[NB_DATA-1]) && (res[NB_DATA-1] != a_q[NB_DATA-1]);
            end
            OP_SUB: begin
                res   = diff[NB_DATA-1:0];
                carry = diff[NB_DATA];
                ovf   = (a_q[NB_DATA-1] != b_q[NB_DATA-1]) && (res[NB_DATA-1] != a_q[NB_DATA-1]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOR: res = ~(a_q | b_q);
            OP_SRL: res = shift_big ? '0 : (a_q >> b_q);
            OP_SRA: res = shift_big ? {NB_DATA{a_q[NB_DATA-1]}} : NB_DATA'($signed(a_q) >>> b_q);
            default: invalid = 1'b1;
        endcase
        zero  = (res == '0) && !invalid;
        flags = {invalid, carry, zero, ovf};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            o_led   <= '0;
            o_flags <= '0;
            o_valid <= 1'b0;
        end else begin
            if (load_a) a_q <= i_SWs;
            if (load_b) b_q <= i_SWs;
            if (exec) begin
                o_led   <= res;
                o_flags <= flags;
                o_valid <= 1'b1;
            end else if (clr_valid) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_state = state;

endmodule
